// File: rtl/aes_ctr_stream.sv
// AES counter-mode stream front end: loads the key into the core, then
// encrypts successive counter blocks and XORs each keystream block with input data.
module aes_ctr_stream #(
  parameter int unsigned CTR_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_start,
  input  logic [255:0] cfg_key,
  input  logic         cfg_keylen,
  input  logic [127:0] cfg_iv,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic         core_encdec,
  output logic         core_init,
  output logic         core_next,
  output logic [255:0] core_key,
  output logic         core_keylen,
  output logic [127:0] core_block,
  input  logic         core_ready,
  input  logic [127:0] core_result,
  input  logic         core_result_valid
);

  typedef enum logic [2:0] {
    IDLE,
    KEY_INIT,
    KEY_WAIT,
    READY,
    CIPHER,
    OUTPUT
  } state_t;

  localparam logic [127:0] CTR_MASK =
    {128{1'b1}} >> (128 - CTR_WIDTH);
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  state_t         state;
  state_t         state_n;
  logic [WDW-1:0] wd;
  logic           waiting;
  logic           timeout;
  logic [127:0]   ctr;
  logic [127:0]   ctr_inc;
  logic [127:0]   data_q;
  logic           last_q;
  logic           next_q;
  logic           done_q;
  logic           err_q;

  assign waiting = (state == KEY_WAIT) || (state == CIPHER);
  assign timeout = waiting && (wd == WDW'(TIMEOUT_CYCLES - 1));

  // Only the low CTR_WIDTH bits roll over; the rest pass through untouched.
  assign ctr_inc = (ctr & ~CTR_MASK) |
                   ((ctr + 128'd1) & CTR_MASK);

  assign busy        = (state != IDLE);
  assign in_ready    = (state == READY);
  assign out_valid   = (state == OUTPUT);
  assign core_init   = (state == KEY_INIT);
  assign core_next   = next_q;
  assign core_block  = ctr;
  assign core_encdec = 1'b1;
  assign done        = done_q;
  assign error       = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     if (cfg_start) state_n = KEY_INIT;
      KEY_INIT: state_n = KEY_WAIT;
      KEY_WAIT: begin
        if (core_ready)   state_n = READY;
        else if (timeout) state_n = IDLE;
      end
      READY:    if (in_valid) state_n = CIPHER;
      CIPHER: begin
        if (core_result_valid) state_n = OUTPUT;
        else if (timeout)      state_n = IDLE;
      end
      OUTPUT: begin
        if (out_ready) state_n = out_last ? IDLE : READY;
      end
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd          <= '0;
      ctr         <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      next_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      core_key    <= '0;
      core_keylen <= 1'b0;
    end else begin
      wd     <= waiting ? wd + WDW'(1) : '0;
      next_q <= (state == READY) && in_valid;
      done_q <= (state == OUTPUT) && out_ready && out_last;
      unique case (state)
        IDLE: begin
          if (cfg_start) begin
            core_key    <= cfg_key;
            core_keylen <= cfg_keylen;
            ctr         <= cfg_iv;
            err_q       <= 1'b0;
          end
        end
        KEY_WAIT: begin
          if (!core_ready && timeout) err_q <= 1'b1;
        end
        READY: begin
          if (in_valid) begin
            data_q <= in_data;
            last_q <= in_last;
          end
        end
        CIPHER: begin
          if (core_result_valid) begin
            out_data <= data_q ^ core_result;
            out_last <= last_q;
            ctr      <= ctr_inc;
          end else if (timeout) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_ctr_stream.sv
// Directed bench for aes_ctr_stream using a hand-driven AES core stand-in
// that returns the SP800-38A F.5.1 keystream blocks.
module tb_aes_ctr_stream;

  logic         clk;
  logic         rst_n;
  logic         cfg_start;
  logic [255:0] cfg_key;
  logic         cfg_keylen;
  logic [127:0] cfg_iv;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_last;
  logic         busy;
  logic         done;
  logic         error;
  logic         core_encdec;
  logic         core_init;
  logic         core_next;
  logic [255:0] core_key;
  logic         core_keylen;
  logic [127:0] core_block;
  logic         core_ready;
  logic [127:0] core_result;
  logic         core_result_valid;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] KEY128 =
    {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] IV  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] IV2 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
  localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C1  = 128'h874d6191b620e3261bef6864990db6ce;
  localparam logic [127:0] C2  = 128'h9806f66b7970fdff8617187bb9fffdff;
  localparam logic [127:0] KS1 = 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
  localparam logic [127:0] KS2 = 128'h362b7c3c6773516318a077d7fc5073ae;
  localparam logic [127:0] WIV = 128'h0123456789abcdef01234567ffffffff;
  localparam logic [127:0] WNX = 128'h0123456789abcdef0123456700000000;
  localparam logic [255:0] KEY256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_ctr_stream dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cfg_start         (cfg_start),
    .cfg_key           (cfg_key),
    .cfg_keylen        (cfg_keylen),
    .cfg_iv            (cfg_iv),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_last           (in_last),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_last          (out_last),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .core_encdec       (core_encdec),
    .core_init         (core_init),
    .core_next         (core_next),
    .core_key          (core_key),
    .core_keylen       (core_keylen),
    .core_block        (core_block),
    .core_ready        (core_ready),
    .core_result       (core_result),
    .core_result_valid (core_result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_outs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_core_next"}, core_next, 0);
    chk({tag, "_core_init"}, core_init, 0);
    chk({tag, "_core_block"}, core_block, 0);
    chk({tag, "_core_key"}, core_key, 0);
    chk({tag, "_encdec"}, core_encdec, 1);
  endtask

  task automatic start(input logic [255:0] key,
                       input logic kl,
                       input logic [127:0] iv);
    cfg_key    = key;
    cfg_keylen = kl;
    cfg_iv     = iv;
    cfg_start  = 1'b1;
    tick();
    cfg_start  = 1'b0;
    chk("init_pulse", core_init, 1);
    chk("core_key", core_key, key);
    chk("core_keylen", core_keylen, kl);
    chk("busy_start", busy, 1);
    chk("err_cleared", error, 0);
    tick();
    chk("init_once", core_init, 0);
    chk("wait_in_ready", in_ready, 0);
    core_ready = 1'b1;
    tick();
    core_ready = 1'b0;
    chk("ready_in_ready", in_ready, 1);
  endtask

  task automatic send(input logic [127:0] d,
                      input logic l,
                      input logic [127:0] blk);
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("next_pulse", core_next, 1);
    chk("core_block", core_block, blk);
    chk("cipher_in_ready", in_ready, 0);
    tick();
    chk("next_once", core_next, 0);
    chk("block_stable", core_block, blk);
  endtask

  task automatic result(input logic [127:0] ks,
                        input logic [127:0] exp_out,
                        input logic exp_last);
    core_result       = ks;
    core_result_valid = 1'b1;
    tick();
    core_result_valid = 1'b0;
    core_result       = '1;
    chk("out_valid", out_valid, 1);
    chk("out_data", out_data, exp_out);
    chk("out_last", out_last, exp_last);
  endtask

  task automatic drain(input logic l);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("drain_out_valid", out_valid, 0);
    if (l) begin
      chk("done_pulse", done, 1);
      chk("busy_end", busy, 0);
      tick();
      chk("done_once", done, 0);
    end else begin
      chk("done_mid", done, 0);
      chk("back_ready", in_ready, 1);
    end
  endtask

  initial begin
    rst_n             = 1'b0;
    cfg_start         = 1'b0;
    cfg_key           = '0;
    cfg_keylen        = 1'b0;
    cfg_iv            = '0;
    in_valid          = 1'b0;
    in_data           = '0;
    in_last           = 1'b0;
    out_ready         = 1'b0;
    core_ready        = 1'b0;
    core_result       = '0;
    core_result_valid = 1'b0;

    tick();
    idle_outs("rst");
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    rst_n = 1'b1;
    tick();
    idle_outs("post_rst");

    // single AES-128 block
    start(KEY128, 1'b0, IV);
    send(P1, 1'b1, IV);
    result(KS1, C1, 1'b1);
    drain(1'b1);

    // two blocks with backpressure on the first
    start(KEY128, 1'b0, IV);
    send(P1, 1'b0, IV);
    result(KS1, C1, 1'b0);
    in_valid  = 1'b1;
    cfg_start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, C1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_core_next", core_next, 0);
      chk("bp_core_init", core_init, 0);
    end
    in_valid  = 1'b0;
    cfg_start = 1'b0;
    drain(1'b0);
    send(P2, 1'b1, IV2);
    result(KS2, C2, 1'b1);
    drain(1'b1);

    // counter wrap, then a block that never completes
    start(KEY256, 1'b1, WIV);
    send(128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a, 1'b0, WIV);
    result(128'h0, 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a, 1'b0);
    drain(1'b0);
    send(P2, 1'b1, WNX);
    for (int i = 0; i < 62; i++) tick();
    chk("to_still_busy", busy, 1);
    chk("to_no_error_yet", error, 0);
    tick();
    chk("to_busy", busy, 0);
    chk("to_error", error, 1);
    chk("to_out_valid", out_valid, 0);
    tick();
    chk("to_error_sticky", error, 1);

    // new session clears error; reset during CIPHER
    start(KEY128, 1'b0, IV);
    send(P1, 1'b1, IV);
    #2;
    rst_n = 1'b0;
    #1;
    idle_outs("arst");
    chk("arst_error", error, 0);
    chk("arst_keylen", core_keylen, 0);
    core_result       = KS1;
    core_result_valid = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    core_result_valid = 1'b0;
    tick();
    idle_outs("arst_rel");
    chk("arst_done", done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/aes_ctr_stream.md
Name: aes_ctr_stream

Overview:
Counter-mode (CTR) streaming front end for the AES core. It loads the key into the core and then encrypts successive counter blocks. Each keystream block is XORed with one 128-bit input data block. The block sits directly upstream of AES_core: it drives init, next, key and block, and consumes result and result_valid. One block is in flight at a time, with a valid/ready stream on both sides.

Parameters:
CTR_WIDTH, 32, number of low-order counter bits incremented per block (1..128); upper bits are never modified.
TIMEOUT_CYCLES, 64, maximum cycles to wait for core_ready or core_result_valid before aborting.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active low
cfg_start  input  1  start session; sampled in IDLE only
cfg_key  input  256  key; AES-128 uses [255:128]
cfg_keylen  input  1  0 = AES-128, 1 = AES-256
cfg_iv  input  128  initial counter block
in_valid  input  1  input data valid
in_ready  output  1  block can accept input
in_data  input  128  plaintext/ciphertext block
in_last  input  1  final block of session
out_valid  output  1  output data valid
out_ready  input  1  downstream accepts output
out_data  output  128  in_data XOR keystream
out_last  output  1  copy of in_last for this block
busy  output  1  state != IDLE
done  output  1  one-cycle pulse after last block accepted downstream
error  output  1  sticky timeout flag; cleared by cfg_start
core_encdec  output  1  tied 1 (encipher)
core_init  output  1  one-cycle pulse to core
core_next  output  1  one-cycle pulse to core
core_key  output  256  registered session key
core_keylen  output  1  registered keylen
core_block  output  128  registered counter block
core_ready  input  1  core key-expansion-done pulse
core_result  input  128  core output block; valid only while core_result_valid
core_result_valid  input  1  core result pulse

Behaviour:
- Reset (async, rst_n low): state IDLE.
  - All outputs 0 except core_encdec = 1.
  - Counter, key and data registers cleared; error cleared.
- States: IDLE, KEY_INIT, KEY_WAIT, READY, CIPHER, OUTPUT.
- IDLE:
  - On cfg_start: latch cfg_key, cfg_keylen, cfg_iv; clear error; go to KEY_INIT.
- KEY_INIT:
  - core_init = 1 for exactly this cycle; go to KEY_WAIT.
- KEY_WAIT:
  - Watchdog counts up from 0.
  - On core_ready: go to READY.
  - If the watchdog reaches TIMEOUT_CYCLES first: set error, go to IDLE.
- READY:
  - in_ready = 1, registered, high only in this state.
  - On in_valid & in_ready: latch in_data and in_last; go to CIPHER.
- CIPHER:
  - core_next = 1 on the first cycle only.
  - core_block holds the counter, stable for the whole state.
  - On core_result_valid:
    - out_data <= latched data XOR core_result, captured in that cycle.
    - out_last <= latched last.
    - Counter low CTR_WIDTH bits increment modulo 2^CTR_WIDTH.
    - Go to OUTPUT.
  - Watchdog timeout: set error, go to IDLE; no output is produced.
- OUTPUT:
  - out_valid = 1; out_data and out_last held stable until out_ready.
  - On out_ready: if out_last, go to IDLE and pulse done next cycle; else go to READY.
- Latency:
  - Input handshake at cycle T → core_next at T+1.
  - Core result pulse at cycle R → out_valid at R+1.
  - Minimum one idle cycle between accepted input blocks.
- core_key and core_keylen are held constant from KEY_INIT until the next cfg_start; core_encdec is constant 1.
- cfg_start outside IDLE is ignored.
- in_valid outside READY is ignored; no data is lost because in_ready = 0.
- Counter wrap: low field all-ones → all-zeros; upper 128−CTR_WIDTH bits unchanged; no flag raised.
- A core_ready or core_result_valid pulse outside its waiting state is ignored.
- Reset mid-operation returns to IDLE immediately; any in-flight block is discarded.

Test Plan:
- AES-128 single block (SP800-38A F.5.1):
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c in [255:128], IV f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, data 6bc1bee22e409f96e93d7e117393172a, last = 1.
  - Required: out_data = 874d6191b620e3261bef6864990db6ce; done pulses once; busy returns to 0.
- Two-block stream, same key/IV:
  - Stimulus: second block ae2d8a571e03ac9c9eb76fac45af8e51.
  - Required: second out_data = 9806f66b7970fdff8617187bb9fffdff; core_block for block 2 = f0f1f2f3f4f5f6f7f8f9fafbfcfdff00.
- Counter wrap:
  - Stimulus: IV low 32 bits = ffffffff.
  - Required: next core_block low 32 bits = 00000000; upper 96 bits unchanged.
- Backpressure:
  - Stimulus: hold out_ready = 0 for 10 cycles.
  - Required: out_valid stays 1, out_data stable, in_ready = 0, no core_next issued.
- Timeout:
  - Stimulus: core model never returns core_result_valid.
  - Required: after 64 cycles in CIPHER, error = 1 and state is IDLE; next cfg_start clears error.
- Async reset asserted during CIPHER:
  - Required: all outputs 0 immediately (core_encdec = 1); no out_valid after release until a new session starts.
